// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID instruction register.
// Define FETCH_PERF_CNT_EN to add the hold/redirect performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] IRD,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] pcD,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`else
    output logic [31:0] pcD
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc_plus4;
    logic        unused_target;

    // Redirect targets are word aligned; the low bits are dropped.
    assign unused_target = ^target[1:0];
    assign pc_plus4      = pc_q + 32'd4;

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        pcd_d = pcd_q;
        if (redirect) begin
            pc_d  = {target[31:2], 2'b00};
            ir_d  = 32'h0;
            pcd_d = 32'h0;
        end else if (stall) begin
            pc_d  = pc_plus4;
            ir_d  = imem_data;
            pcd_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ir_q  <= 32'h0;
            pcd_q <= 32'h0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            pcd_q <= pcd_d;
        end
    end

    assign imem_addr = pc_q;
    assign IRD       = ir_q;
    assign pcD       = pcd_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            if (flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end else if (!stall) begin
            if (stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with RESET_PC = 32'h100.
// Counter checks are compiled in only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] IRD;
    logic [31:0] pcD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .redirect  (redirect),
        .target    (target),
        .imem_data (imem_data),
        .imem_addr (imem_addr),
        .IRD       (IRD),
`ifdef FETCH_PERF_CNT_EN
        .pcD       (pcD),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`else
        .pcD       (pcD)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag,
                               input logic [31:0] addr,
                               input logic [31:0] ir,
                               input logic [31:0] pcd);
        check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".ird"}, IRD, ir);
        check({tag, ".pcd"}, pcD, pcd);
    endtask

    task automatic check_cnt(input string tag,
                             input logic [31:0] sc,
                             input logic [31:0] fc);
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt, sc);
        check({tag, ".flush_cnt"}, flush_cnt, fc);
`else
        if (tag.len() == 0 && sc != fc) begin
            $display("note: counters absent in this build");
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b1;
        redirect  = 1'b0;
        target    = 32'h0;
        imem_data = 32'h0;

        step();
        step();
        check_state("reset", 32'h100, 32'h0, 32'h0);
        check_cnt("reset", 32'd0, 32'd0);

        rst       = 1'b0;
        imem_data = 32'h2108_0001;
        step();
        check_state("advance", 32'h104, 32'h2108_0001, 32'h104);

        stall     = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("hold", 32'h104, 32'h2108_0001, 32'h104);
        end
        check_cnt("hold", 32'd3, 32'd0);

        redirect = 1'b1;
        target   = 32'h203;
        step();
        check_state("redir", 32'h200, 32'h0, 32'h0);
        check_cnt("redir", 32'd3, 32'd1);

        redirect  = 1'b0;
        stall     = 1'b1;
        imem_data = 32'h0;
        step();
        check_state("nop", 32'h204, 32'h0, 32'h204);

        imem_data = 32'h00A0_0093;
        step();
        check_state("adv2", 32'h208, 32'h00A0_0093, 32'h208);

        redirect = 1'b1;
        target   = 32'hFFFF_FFFF;
        step();
        check_state("redir_hi", 32'hFFFF_FFFC, 32'h0, 32'h0);
        check_cnt("redir_hi", 32'd3, 32'd2);

        redirect  = 1'b0;
        imem_data = 32'h1234_5678;
        step();
        check_state("wrap", 32'h0, 32'h1234_5678, 32'h0);

        stall = 1'b0;
        step();
        check_state("hold2", 32'h0, 32'h1234_5678, 32'h0);
        check_cnt("hold2", 32'd4, 32'd2);

        rst = 1'b1;
        step();
        check_state("rst_hold", 32'h100, 32'h0, 32'h0);
        check_cnt("rst_hold", 32'd0, 32'd0);

        stall    = 1'b1;
        redirect = 1'b1;
        target   = 32'h300;
        step();
        check_state("rst_redir", 32'h100, 32'h0, 32'h0);
        check_cnt("rst_redir", 32'd0, 32'd0);

        rst       = 1'b0;
        redirect  = 1'b0;
        imem_data = 32'h0000_0011;
        step();
        check_state("post_rst", 32'h104, 32'h0000_0011, 32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
